// File: rtl/tlb_refill_walker.sv
// tlb_refill_walker: two-level page-table walker in front of the TLB fill port.
// On a miss (start) it reads the L1 PTE, then the L2 PTE, and issues a one-cycle
// TLB write of {pid, vpn} -> ppn. An invalid PTE or a bus timeout produces a
// one-cycle fault pulse with a code. Only one walk is in flight at a time.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start/kmode/pid/vaddr/ptbr  walk request; the request fields are latched when start is taken in IDLE
//   abort                    cancel the walk, with no TLB write and no fault
//   mem_req/mem_addr/mem_ready  read request channel (single outstanding)
//   mem_rvalid/mem_rdata     read response, one per accepted request
//   tlb_we/tlb_key/tlb_data  TLB fill strobe and payload
//   busy/done/fault/fault_code  walker status; done and fault are one-cycle pulses
module tlb_refill_walker #(
  parameter int PA_W    = 18,
  parameter int PPN_W   = PA_W - 12,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kmode,
  input  logic [11:0]     pid,
  input  logic [31:0]     vaddr,
  input  logic [PA_W-1:0] ptbr,
  input  logic            abort,
  output logic            mem_req,
  output logic [PA_W-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            tlb_we,
  output logic [31:0]     tlb_key,
  output logic [31:0]     tlb_data,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic [7:0]      fault_code
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, FILL, FAULT, DRAIN
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             kmode_q;
  logic [11:0]      pid_q;
  logic [19:0]      vpn_q;
  logic [7:0]       code_nxt;
  logic             in_wait, tmo;
  logic [PPN_W-1:0] pte_ppn;
  logic             unused;

  assign pte_ppn = mem_rdata[12 +: PPN_W];
  assign in_wait = state inside {L1_WAIT, L2_WAIT, DRAIN};
  // This cycle is the TIMEOUT-th without a response: give up now.
  assign tmo     = in_wait && !mem_rvalid && (cnt >= CNT_W'(TIMEOUT - 1));
  assign unused  = ^{ptbr[11:0], vaddr[11:0], mem_rdata[31:12+PPN_W], mem_rdata[11:1]};

  always_comb begin
    state_nxt = state;
    code_nxt  = 8'h00;
    case (state)
      IDLE:    if (start && !abort) state_nxt = L1_REQ;
      L1_REQ:  if (abort) state_nxt = IDLE; else if (mem_ready) state_nxt = L1_WAIT;
      L2_REQ:  if (abort) state_nxt = IDLE; else if (mem_ready) state_nxt = L2_WAIT;
      L1_WAIT, L2_WAIT: begin
        if (abort) begin
          // A response landing with the abort is already consumed; nothing to drain.
          if (mem_rvalid || tmo) state_nxt = IDLE;
          else                   state_nxt = DRAIN;
        end else if (mem_rvalid) begin
          if (!mem_rdata[0]) begin
            state_nxt = FAULT;
            code_nxt  = kmode_q ? 8'h85 : 8'h84;
          end else if (state == L1_WAIT) begin
            state_nxt = L2_REQ;
          end else begin
            state_nxt = FILL;
          end
        end else if (tmo) begin
          state_nxt = FAULT;
          code_nxt  = 8'h86;
        end
      end
      DRAIN:   if (mem_rvalid || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      kmode_q    <= 1'b0;
      pid_q      <= '0;
      vpn_q      <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      tlb_we     <= 1'b0;
      tlb_key    <= '0;
      tlb_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= '0;
    end else begin
      state      <= state_nxt;
      // Status and strobes are decoded from the next state so they leave a flop.
      busy       <= (state_nxt != IDLE);
      mem_req    <= (state_nxt == L1_REQ) || (state_nxt == L2_REQ);
      tlb_we     <= (state_nxt == FILL);
      done       <= (state_nxt == FILL);
      fault      <= (state_nxt == FAULT);
      fault_code <= code_nxt;

      // Counter is held at zero during REQ so WAIT always starts from 0; it
      // keeps running through DRAIN and saturates instead of wrapping.
      if (state == L1_REQ || state == L2_REQ)
        cnt <= '0;
      else if (in_wait && !mem_rvalid && cnt != CNT_W'(TIMEOUT))
        cnt <= cnt + 1'b1;

      if (state == IDLE && state_nxt == L1_REQ) begin
        kmode_q  <= kmode;
        pid_q    <= pid;
        vpn_q    <= vaddr[31:12];
        mem_addr <= {ptbr[PA_W-1:12], vaddr[31:22], 2'b00};
      end
      if (state == L1_WAIT && state_nxt == L2_REQ)
        mem_addr <= {pte_ppn, vpn_q[9:0], 2'b00};
      if (state == L2_WAIT && state_nxt == FILL) begin
        tlb_key  <= {pid_q, vpn_q};
        tlb_data <= 32'(pte_ppn);
      end
    end
  end
endmodule

// File: tb/tb_tlb_refill_walker.sv
module tb_tlb_refill_walker;
  localparam int PA_W = 18;

  logic            clk, rst, start, kmode, abort;
  logic [11:0]     pid;
  logic [31:0]     vaddr;
  logic [PA_W-1:0] ptbr;
  logic            mem_req, mem_ready, mem_rvalid;
  logic [PA_W-1:0] mem_addr;
  logic [31:0]     mem_rdata;
  logic            tlb_we, busy, done, fault;
  logic [31:0]     tlb_key, tlb_data;
  logic [7:0]      fault_code;

  tlb_refill_walker #(.PA_W(PA_W), .PPN_W(6), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .kmode(kmode), .pid(pid), .vaddr(vaddr),
    .ptbr(ptbr), .abort(abort), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .tlb_we(tlb_we), .tlb_key(tlb_key), .tlb_data(tlb_data), .busy(busy),
    .done(done), .fault(fault), .fault_code(fault_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        we;
    logic        dn;
    logic        flt;
    logic [31:0] key;
    logic [31:0] data;
    logic [7:0]  code;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  ev_t e, got;
  int  obs_rd = 0;
  int  checks = 0;
  int  errors = 0;

  function automatic ev_t fill_ev(input logic [31:0] k, input logic [31:0] d);
    return ev_t'({1'b1, 1'b1, 1'b0, k, d, 8'h00});
  endfunction
  function automatic ev_t fault_ev(input logic [7:0] c);
    return ev_t'({1'b0, 1'b0, 1'b1, 32'h0, 32'h0, c});
  endfunction

  // Output monitor: every strobe cycle becomes one observed event.
  always @(negedge clk) begin
    if (tlb_we || done || fault)
      obs_q.push_back(ev_t'({tlb_we, done, fault, tlb_we ? tlb_key : 32'h0,
                             tlb_we ? tlb_data : 32'h0, fault ? fault_code : 8'h00}));
  end

  // Memory responder: holds mem_ready low for stall_cycles per request, answers
  // resp_delay cycles after acceptance (1 = the cycle right after).
  logic [31:0]     mem [logic [PA_W-1:0]];
  int              resp_delay = 1;
  int              stall_cycles = 0;
  int              pend = 0;
  int              rq_wait = 0;
  bit              acc = 0;
  logic [PA_W-1:0] acc_addr;
  logic [31:0]     pdata;

  initial begin
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_ready  = 1'b0;
      if (rst) begin
        pend = 0; acc = 0; rq_wait = 0;
      end else begin
        if (acc) begin
          acc   = 0;
          pend  = resp_delay;
          pdata = mem.exists(acc_addr) ? mem[acc_addr] : 32'h0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin mem_rvalid = 1'b1; mem_rdata = pdata; end
        end
        if (!mem_req) rq_wait = 0;
        else if (rq_wait < stall_cycles) rq_wait++;
        else begin mem_ready = 1'b1; acc = 1; acc_addr = mem_addr; rq_wait = 0; end
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic do_start(input logic km, input logic [11:0] p, input logic [31:0] va,
                          input logic [PA_W-1:0] pt);
    kmode = km; pid = p; vaddr = va; ptbr = pt; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({mem_req, mem_addr, tlb_we, tlb_key, tlb_data, busy, done, fault, fault_code} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h we=%b busy=%b fault=%b, required all 0",
               mem_req, mem_addr, tlb_we, busy, fault);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_happy();
    int lat;
    exp_q.push_back(fill_ev(32'h00500403, 32'h0000000B));
    step();
    do_start(1'b0, 12'h005, 32'h00403ABC, 18'h01000);
    lat = 1;
    while (!tlb_we && lat < 50) begin step(); lat++; end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL happy_latency: got %0d cycles, required 5", lat); end
    repeat (3) step();
    e = exp_q.pop_front(); got = (obs_q.size() > obs_rd) ? obs_q[obs_rd] : '0; checks++;
    if (obs_q.size() != obs_rd + 1 || got !== e) begin
      errors++;
      $display("FAIL happy_fill: %0d events first=%h, required 1 event %h", obs_q.size() - obs_rd, got, e);
    end
    obs_rd = obs_q.size();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL happy_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_invalid_pte();
    int n;
    // L1 entry absent (reads 0) in kernel mode
    exp_q.push_back(fault_ev(8'h85));
    do_start(1'b1, 12'h00A, 32'h00C00000, 18'h03000);
    n = 0;
    while (!fault && n < 50) begin step(); n++; end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL l1_busy_after_fault: busy=%b, required 0", busy); end
    step();
    e = exp_q.pop_front(); got = (obs_q.size() > obs_rd) ? obs_q[obs_rd] : '0; checks++;
    if (obs_q.size() != obs_rd + 1 || got !== e) begin
      errors++;
      $display("FAIL l1_fault: %0d events first=%h, required 1 event %h", obs_q.size() - obs_rd, got, e);
    end
    obs_rd = obs_q.size();
    // L1 valid, L2 entry absent, user mode
    exp_q.push_back(fault_ev(8'h84));
    do_start(1'b0, 12'h00A, 32'h00800000, 18'h03000);
    repeat (10) step();
    e = exp_q.pop_front(); got = (obs_q.size() > obs_rd) ? obs_q[obs_rd] : '0; checks++;
    if (obs_q.size() != obs_rd + 1 || got !== e) begin
      errors++;
      $display("FAIL l2_fault: %0d events first=%h, required 1 event %h", obs_q.size() - obs_rd, got, e);
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_timeout();
    int n, c;
    resp_delay = 7;
    exp_q.push_back(fault_ev(8'h86));
    do_start(1'b1, 12'h005, 32'h00403ABC, 18'h01000);
    n = 0;
    while (!(mem_req && mem_ready) && n < 20) begin step(); n++; end
    c = 0;
    while (!fault && c < 20) begin step(); c++; end
    checks++;
    if (c - 1 != 4) begin errors++; $display("FAIL timeout_cycles: got %0d after WAIT entry, required 4", c - 1); end
    repeat (8) step();  // late rvalid arrives in here
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: busy=%b req=%b, required 0 0", busy, mem_req);
    end
    e = exp_q.pop_front(); got = (obs_q.size() > obs_rd) ? obs_q[obs_rd] : '0; checks++;
    if (obs_q.size() != obs_rd + 1 || got !== e) begin
      errors++;
      $display("FAIL timeout_fault: %0d events first=%h, required 1 event %h", obs_q.size() - obs_rd, got, e);
    end
    obs_rd = obs_q.size();
    resp_delay = 1;
  endtask

  task automatic test_abort();
    int n;
    // abort inside L2_WAIT; response comes 3 cycles after the abort
    do_start(1'b0, 12'h005, 32'h00403ABC, 18'h01000);
    n = 0;
    while (!(mem_req && mem_addr == 18'h0200C) && n < 20) begin step(); n++; end
    resp_delay = 4;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step(); step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_drain_busy: busy=%b, required 1", busy); end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_drain_done: busy=%b, required 0", busy); end
    resp_delay = 1;
    repeat (3) step();
    checks++;
    if (obs_q.size() != obs_rd) begin
      errors++; $display("FAIL abort_no_event: got %0d events, required 0", obs_q.size() - obs_rd);
    end
    obs_rd = obs_q.size();
    exp_q.push_back(fill_ev(32'h12300403, 32'h0000000B));
    do_start(1'b0, 12'h123, 32'h00403000, 18'h01000);
    repeat (8) step();
    e = exp_q.pop_front(); got = (obs_q.size() > obs_rd) ? obs_q[obs_rd] : '0; checks++;
    if (obs_q.size() != obs_rd + 1 || got !== e) begin
      errors++;
      $display("FAIL abort_next_walk: %0d events first=%h, required 1 event %h", obs_q.size() - obs_rd, got, e);
    end
    obs_rd = obs_q.size();
    // abort together with start in IDLE
    abort = 1'b1;
    do_start(1'b0, 12'h123, 32'h00403000, 18'h01000);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_with_start: busy=%b, required 0", busy); end
    // abort in L1_REQ while the bus stalls
    stall_cycles = 10;
    do_start(1'b0, 12'h123, 32'h00403000, 18'h01000);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL abort_in_req: busy=%b req=%b, required 0 0", busy, mem_req);
    end
    stall_cycles = 0;
    repeat (4) step();
    checks++;
    if (obs_q.size() != obs_rd) begin
      errors++; $display("FAIL abort_req_no_event: got %0d events, required 0", obs_q.size() - obs_rd);
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_backpressure();
    bit stable;
    stall_cycles = 6;
    exp_q.push_back(fill_ev(32'h0AB00403, 32'h0000000B));
    do_start(1'b0, 12'h0AB, 32'h00403ABC, 18'h01000);
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (!(mem_req === 1'b1 && mem_addr === 18'h01004 && mem_ready === 1'b0)) stable = 1'b0;
      start = i[0];  // start pulses while busy must be ignored
      vaddr = 32'hFFFFF000;
      pid   = 12'hEEE;
      step();
    end
    start = 1'b0;
    stall_cycles = 0;
    checks++;
    if (!stable) begin errors++; $display("FAIL backpressure_hold: req/addr changed, required held at 1/01004"); end
    repeat (8) step();
    e = exp_q.pop_front(); got = (obs_q.size() > obs_rd) ? obs_q[obs_rd] : '0; checks++;
    if (obs_q.size() != obs_rd + 1 || got !== e) begin
      errors++;
      $display("FAIL backpressure_fill: %0d events first=%h, required 1 event %h", obs_q.size() - obs_rd, got, e);
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_reset_mid();
    int n;
    resp_delay = 20;
    do_start(1'b0, 12'h005, 32'h00403ABC, 18'h01000);
    n = 0;
    while (!(mem_req && mem_ready) && n < 20) begin step(); n++; end
    step();
    checks++;
    if (busy !== 1'b1 || mem_addr !== 18'h01004) begin
      errors++; $display("FAIL rst_mid_pre: busy=%b addr=%h, required 1 01004", busy, mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_addr, tlb_we, tlb_key, tlb_data, busy, done, fault, fault_code} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: busy=%b addr=%h req=%b, required all 0", busy, mem_addr, mem_req);
    end
    step(); step();
    rst = 1'b0;
    resp_delay = 1;
    exp_q.push_back(fill_ev(32'h7FF00403, 32'h0000000B));
    do_start(1'b1, 12'h7FF, 32'h00403FFF, 18'h01000);
    repeat (8) step();
    e = exp_q.pop_front(); got = (obs_q.size() > obs_rd) ? obs_q[obs_rd] : '0; checks++;
    if (obs_q.size() != obs_rd + 1 || got !== e) begin
      errors++;
      $display("FAIL rst_mid_fresh_walk: %0d events first=%h, required 1 event %h", obs_q.size() - obs_rd, got, e);
    end
    obs_rd = obs_q.size();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; kmode = 1'b0;
    pid = '0; vaddr = '0; ptbr = '0;
    mem[18'h01004] = 32'h00002001;
    mem[18'h0200C] = 32'h0000B001;
    mem[18'h03008] = 32'h00004001;
    test_reset();
    test_happy();
    test_invalid_pte();
    test_timeout();
    test_abort();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
